hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/freeze decode for the
// 5-stage core, with hung-access detection and saturating counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_er,
  input  logic [4:0]       ex_AW,
  input  logic             mem_pcsrc,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_er,
  input  logic             mem_ew,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN, MEM_WAIT, ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_busy, redirect, load_use;
  logic decode, take_rdr;

  assign mem_busy = (mem_er | mem_ew) & ~dmem_ready;
  assign redirect = (mem_pcsrc & mem_zero) | mem_jump;
  assign load_use = ex_er & (ex_AW != 5'd0) &
                    ((ex_AW == id_rs) |
                     (id_uses_rt & (ex_AW == id_rt)));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    decode    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end else begin
          decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          decode  = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // Freeze unless decoding; redirect outranks load-use.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    take_rdr    = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (decode) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      if (redirect) begin
        take_rdr    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (take_rdr && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected control vectors are queued
// when stimulus is driven and popped when the outputs settle.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] V_RUN = 7'b1101010;
  localparam logic [6:0] V_FRZ = 7'b0000000;
  localparam logic [6:0] V_RDR = 7'b1111111;
  localparam logic [6:0] V_LU  = 7'b0001110;
  localparam logic [6:0] V_RST = 7'b0010101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_AW = '0;
  logic          id_uses_rt = 0, ex_er = 0;
  logic          mem_pcsrc = 0, mem_zero = 0, mem_jump = 0;
  logic          mem_er = 0, mem_ew = 0, dmem_ready = 0;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic          exmem_en, exmem_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctl;

  int         n_run = 0;
  int         n_fail = 0;
  logic [6:0] exp_q[$];
  logic [6:0] e;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_er(ex_er), .ex_AW(ex_AW),
    .mem_pcsrc(mem_pcsrc), .mem_zero(mem_zero),
    .mem_jump(mem_jump), .mem_er(mem_er), .mem_ew(mem_ew),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_en, exmem_flush};

  always #5 clk = ~clk;

  task automatic drive(
    input logic [4:0] rs, input logic [4:0] rt, input logic urt,
    input logic er, input logic [4:0] aw,
    input logic pcs, input logic zr, input logic jmp,
    input logic mer, input logic mew, input logic rdy,
    input logic [6:0] v
  );
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_er = er; ex_AW = aw;
    mem_pcsrc = pcs; mem_zero = zr; mem_jump = jmp;
    mem_er = mer; mem_ew = mew; dmem_ready = rdy;
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_er = 0; ex_AW = '0;
    mem_pcsrc = 0; mem_zero = 0; mem_jump = 0;
    mem_er = 0; mem_ew = 0; dmem_ready = 0;
    exp_q.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_er = 1; ex_AW = 5'd5; id_rs = 5'd5;
    exp_q.push_back(V_RST);
    #3;
    e = exp_q.pop_front();
    n_run++;
    if (ctl !== e) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want %b", ctl, e);
    end
    n_run++;
    if ({mem_timeout, stall_cnt, flush_cnt} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state got to=%b st=%0d fl=%0d want 0",
               mem_timeout, stall_cnt, flush_cnt);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, V_LU);
    #2 e = exp_q.pop_front();
    n_run++;
    if (ctl !== e) begin
      n_fail++;
      $display("FAIL lu_ctl got %b want %b", ctl, e);
    end
    @(posedge clk); #1;
    n_run++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_stall got %0d want 1", stall_cnt);
    end
    drive(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, V_RUN);
    #2 e = exp_q.pop_front();
    n_run++;
    if (ctl !== e) begin
      n_fail++;
      $display("FAIL lu_release got %b want %b", ctl, e);
    end
  endtask

  task automatic test_rt_gating();
    do_reset();
    drive(0, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, V_RUN);
    drive(0, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, V_LU);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, V_RUN);
    drive(9, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, V_RUN);
    @(negedge clk);
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, V_RUN);
        1: drive(0, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0, V_LU);
        2: drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, V_RUN);
        default: drive(9, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, V_RUN);
      endcase
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL rt_gate[%0d] got %b want %b", i, ctl, e);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rt_stall got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(5, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, V_RDR);
        1: drive(5, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, V_LU);
        default: drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, V_RDR);
      endcase
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL branch[%0d] got %b want %b", i, ctl, e);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        n_run++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
          n_fail++;
          $display("FAIL branch_cnt got fl=%0d st=%0d want 1/0",
                   flush_cnt, stall_cnt);
        end
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (flush_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL branch_cnt2 got fl=%0d st=%0d want 2/1",
               flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3)
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, V_FRZ);
      else if (i == 3)
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, V_RUN);
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RUN);
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL memwait[%0d] got %b want %b", i, ctl, e);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (stall_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL memwait_stall got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_FRZ);
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL to_wait[%0d] got %b want %b", i, ctl, e);
      end
      @(posedge clk); #1;
      n_run++;
      if (mem_timeout !== (i == 4)) begin
        n_fail++;
        $display("FAIL to_flag[%0d] got %b want %b",
                 i, mem_timeout, (i == 4));
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, V_FRZ);
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL err_frz[%0d] got %b want %b", i, ctl, e);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (mem_timeout !== 1'b1 || stall_cnt !== 4'd15 ||
        flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL err_hold got to=%b st=%0d fl=%0d want 1/15/0",
               mem_timeout, stall_cnt, flush_cnt);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (mem_timeout !== 1'b0 || stall_cnt !== 4'd0 || ctl !== V_RST) begin
      n_fail++;
      $display("FAIL async_rst got to=%b st=%0d ctl=%b want 0/0/%b",
               mem_timeout, stall_cnt, ctl, V_RST);
    end
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RUN);
    #2 e = exp_q.pop_front();
    n_run++;
    if (ctl !== e) begin
      n_fail++;
      $display("FAIL post_rst got %b want %b", ctl, e);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, V_RDR);
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL sat_ctl[%0d] got %b want %b", i, ctl, e);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (flush_cnt !== 4'd15 || stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_cnt got fl=%0d st=%0d want 15/0",
               flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1: drive(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, V_LU);
        2: drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, V_FRZ);
        3: drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, V_RDR);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, V_RUN);
      endcase
      #2 e = exp_q.pop_front();
      n_run++;
      if (ctl !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] got %b want %b", i, ctl, e);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_cnt got st=%0d fl=%0d want 3/1",
               stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
